hi_lo_unit: RTL and testbench
=============================

Name: hi_lo_unit

Overview:
Execute-stage multiply/divide unit that owns the architectural HI and LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Provides HI/LO to the execute-stage 4-input result mux as the MFHI/MFLO sources.
- Divide is iterative. `busy` drives the hazard unit's stall of MFHI/MFLO and of new HI/LO ops.

Parameters:
- WIDTH, 32, operand and HI/LO register width. The divide takes WIDTH iterations.

Ports:
- clk  input  1  system clock (the single clock), rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- op_valid  input  1  an op is presented this cycle.
- op  input  3  hl_op_t operation code.
- operand_a  input  WIDTH  rs value (multiplicand/dividend, MTHI/MTLO source).
- operand_b  input  WIDTH  rt value (multiplier/divisor).
- cancel  input  1  exception flush; aborts a running divide.
- busy  output  1  divide in progress.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset, asserted at any time including mid-divide:
  - hi=0, lo=0, busy=0, state=IDLE.
  - Iteration counter and partial remainder/quotient are cleared.
- States:
  - IDLE: accepts ops.
  - DIV_RUN: iterative divide.
- IDLE with op_valid=1:
  - HL_NOP: no effect.
  - MULT/MULTU: full 2*WIDTH product, signed or unsigned. {hi,lo} are written at the accepting edge, so the result is visible next cycle. busy stays 0.
  - MTHI: hi<=operand_a at the accepting edge. MTLO: lo<=operand_a. The other register is unchanged.
  - DIV/DIVU with operand_b==0: lo<=all ones, hi<=operand_a at the accepting edge. No DIV_RUN entry, busy stays 0.
  - DIV/DIVU with operand_b!=0:
    - Latch operand magnitudes (signed: absolute values), quotient/remainder sign flags and counter=0.
    - Go to DIV_RUN; busy=1 from the next cycle.
- DIV_RUN:
  - One restoring-division quotient bit per edge, with a WIDTH+1-bit subtractor.
  - busy is high for exactly WIDTH cycles.
  - On the WIDTH-th iteration edge: write lo=quotient and hi=remainder, sign-corrected, then return to IDLE with busy=0.
- Signed rules:
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the dividend's sign (truncation toward zero).
  - -2^(WIDTH-1) / -1: lo=0x80000000, hi=0.
- op_valid while busy=1: ignored. The hazard unit must hold the op upstream.
- HI/LO during a divide: keep their old values until the completion edge.
- cancel=1 in DIV_RUN: return to IDLE at the next edge, busy=0, hi/lo unchanged.
- cancel=1 in IDLE: the op presented that cycle is discarded.
- cancel takes priority over completion on the same edge.
- No forwarding inside the block: MFHI in the cycle after MULT reads the registered value.

Decomposition:
- Package hi_lo_pkg holds:
  - typedef enum logic [2:0] hl_op_t: HL_NOP=0, HL_MULT=1, HL_MULTU=2, HL_DIV=3, HL_DIVU=4, HL_MTHI=5, HL_MTLO=6.
  - typedef enum logic hl_state_t: IDLE, DIV_RUN.
- Sub-module div_iter holds the restoring-divide datapath: remainder/quotient shift registers, counter, done flag.
- hi_lo_unit holds the FSM, the multiplier, sign handling and the HI/LO registers.

Test Plan:
- MULT a=0xFFFFFFFF, b=0x00000002 -> next cycle hi=0xFFFFFFFF, lo=0xFFFFFFFE, busy never asserts. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIVU a=100, b=7 -> busy high exactly 32 cycles, hi/lo unchanged during them, then lo=0x0000000E, hi=0x00000002. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=0x1234, b=0 -> next cycle lo=0xFFFFFFFF, hi=0x1234, busy=0.
- Start DIVU 100/7, assert cancel at busy cycle 10 -> busy=0 next cycle, hi/lo keep prior values. Issue MULT during a divide -> ignored, hi/lo change only at divide completion.
- Assert reset_n=0 asynchronously mid-divide between clock edges -> busy, hi, lo go to 0 immediately. Issue MTHI 0xDEADBEEF after release -> hi=0xDEADBEEF, lo=0.

Source files
------------

// File: rtl/hi_lo_pkg.sv
// Shared types for the HI/LO multiply/divide unit: operation codes and FSM states.
package hi_lo_pkg;

  localparam int unsigned HL_WIDTH = 32;

  typedef enum logic [2:0] {
    HL_NOP   = 3'd0,
    HL_MULT  = 3'd1,
    HL_MULTU = 3'd2,
    HL_DIV   = 3'd3,
    HL_DIVU  = 3'd4,
    HL_MTHI  = 3'd5,
    HL_MTLO  = 3'd6
  } hl_op_t;

  typedef enum logic {
    IDLE    = 1'b0,
    DIV_RUN = 1'b1
  } hl_state_t;

endpackage

// File: rtl/hi_lo_unit_div_iter.sv
// Restoring unsigned divider datapath: one quotient bit per step, WIDTH steps per divide.
module div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done_c,
  output logic [WIDTH-1:0] quot_next_c,
  output logic [WIDTH-1:0] rem_next_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] dsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             ge;

  // Top bit of the WIDTH+1-bit difference is the borrow: set means the trial subtract failed.
  always_comb begin
    shifted     = {rem_q, quot_q[WIDTH-1]};
    trial       = shifted - {1'b0, dsr_q};
    ge          = ~trial[WIDTH];
    rem_next_c  = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quot_next_c = {quot_q[WIDTH-2:0], ge};
    done_c      = step && (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q  <= '0;
      quot_q <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      rem_q  <= '0;
      quot_q <= dividend;
      dsr_q  <= divisor;
      cnt_q  <= '0;
    end else if (step) begin
      rem_q  <= rem_next_c;
      quot_q <= quot_next_c;
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hi_lo_unit.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
module hi_lo_unit
  import hi_lo_pkg::*;
#(
  parameter int unsigned WIDTH = HL_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  hl_state_t          state_q, state_d;
  hl_op_t             op_e;
  logic [WIDTH-1:0]   hi_d, lo_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d;
  logic               div_start_c;
  logic               is_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               done_c;
  logic [WIDTH-1:0]   quot_next_c, rem_next_c;

  assign op_e = hl_op_t'(op);

  // Sign-extended operands give the signed product in the low 2*WIDTH bits.
  always_comb begin
    is_signed = (op_e == HL_DIV);
    a_mag     = (is_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    b_mag     = (is_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;
    prod_u    = {{WIDTH{1'b0}}, operand_a} * {{WIDTH{1'b0}}, operand_b};
    prod_s    = {{WIDTH{operand_a[WIDTH-1]}}, operand_a} *
                {{WIDTH{operand_b[WIDTH-1]}}, operand_b};
  end

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (div_start_c),
    .step       (state_q == DIV_RUN),
    .dividend   (a_mag),
    .divisor    (b_mag),
    .done_c     (done_c),
    .quot_next_c(quot_next_c),
    .rem_next_c (rem_next_c)
  );

  always_comb begin
    state_d     = state_q;
    hi_d        = hi;
    lo_d        = lo;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    div_start_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid && !cancel) begin
          case (op_e)
            HL_MULT:  {hi_d, lo_d} = prod_s;
            HL_MULTU: {hi_d, lo_d} = prod_u;
            HL_MTHI:  hi_d = operand_a;
            HL_MTLO:  lo_d = operand_a;
            HL_DIV, HL_DIVU: begin
              if (operand_b == '0) begin
                lo_d = '1;
                hi_d = operand_a;
              end else begin
                div_start_c = 1'b1;
                qneg_d      = is_signed && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                rneg_d      = is_signed && operand_a[WIDTH-1];
                state_d     = DIV_RUN;
              end
            end
            default: ;
          endcase
        end
      end
      DIV_RUN: begin
        // Flush wins over a completion landing on the same edge.
        if (cancel) begin
          state_d = IDLE;
        end else if (done_c) begin
          lo_d    = qneg_q ? -quot_next_c : quot_next_c;
          hi_d    = rneg_q ? -rem_next_c : rem_next_c;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hi      <= '0;
      lo      <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi      <= hi_d;
      lo      <= lo_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign busy = (state_q == DIV_RUN);

endmodule

// File: tb/tb_hi_lo_unit.sv
// Scoreboard bench for hi_lo_unit: expected {hi,lo} queued at issue, popped when the result lands.
module tb_hi_lo_unit;
  import hi_lo_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        cancel = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] sb_q[$];
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  hi_lo_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op_valid (op_valid),
    .op       (op),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .cancel   (cancel),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    int si, sj;
    case (o)
      HL_MULT: begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
      end
      HL_MULTU: return {32'd0, a} * {32'd0, b};
      HL_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        si = a;
        sj = b;
        return {32'(si % sj), 32'(si / sj)};
      end
      HL_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      HL_MTHI: return {a, exp_lo};
      HL_MTLO: return {exp_hi, a};
      default: return {exp_hi, exp_lo};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid  = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    step();
    op_valid  = 1'b0;
    op        = HL_NOP;
  endtask

  // Counts busy cycles (bounded) and notes whether hi/lo ever moved off the expected old values.
  task automatic wait_div(output int cyc, output bit held);
    cyc  = 0;
    held = 1'b1;
    while (busy === 1'b1 && cyc < 100) begin
      if (hi !== exp_hi || lo !== exp_lo) held = 1'b0;
      cyc++;
      step();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
  endtask

  task automatic test_mult();
    logic [63:0] e;
    sb_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFE});
    drive(HL_MULT, 32'hFFFF_FFFF, 32'h2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy: got %b want 0", busy); end
    e = sb_q.pop_front(); {exp_hi, exp_lo} = e;
    checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL mult: got %h want %h", {hi, lo}, e); end
    sb_q.push_back({32'h1, 32'hFFFF_FFFE});
    drive(HL_MULTU, 32'hFFFF_FFFF, 32'h2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy: got %b want 0", busy); end
    e = sb_q.pop_front(); {exp_hi, exp_lo} = e;
    checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL multu: got %h want %h", {hi, lo}, e); end
  endtask

  task automatic test_div();
    logic [63:0] e;
    logic [2:0]  ops [3] = '{HL_DIVU, HL_DIV, HL_DIV};
    logic [31:0] as  [3] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000};
    logic [31:0] bs  [3] = '{32'd7, 32'd2, 32'hFFFF_FFFF};
    logic [63:0] es  [3] = '{{32'd2, 32'hE}, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd0, 32'h8000_0000}};
    int cyc;
    bit held;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(es[i]);
      drive(ops[i], as[i], bs[i]);
      wait_div(cyc, held);
      checks++; if (cyc != 32) begin errors++; $display("FAIL div%0d_busy_cycles: got %0d want 32", i, cyc); end
      checks++; if (!held) begin errors++; $display("FAIL div%0d_hold: hi/lo moved during divide, want %h", i, {exp_hi, exp_lo}); end
      e = sb_q.pop_front(); {exp_hi, exp_lo} = e;
      checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL div%0d_result: got %h want %h", i, {hi, lo}, e); end
    end
    sb_q.push_back({32'h1234, 32'hFFFF_FFFF});
    drive(HL_DIVU, 32'h1234, 32'd0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divzero_busy: got %b want 0", busy); end
    e = sb_q.pop_front(); {exp_hi, exp_lo} = e;
    checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL divzero: got %h want %h", {hi, lo}, e); end
  endtask

  task automatic test_move();
    logic [63:0] e;
    sb_q.push_back({exp_hi, exp_lo});
    cancel = 1'b1;
    drive(HL_MTHI, 32'h5555_5555, 32'd0);
    cancel = 1'b0;
    e = sb_q.pop_front(); {exp_hi, exp_lo} = e;
    checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL cancel_idle: got %h want %h", {hi, lo}, e); end
    sb_q.push_back(model(HL_MTLO, 32'hA5A5_0001, 32'd0));
    drive(HL_MTLO, 32'hA5A5_0001, 32'd0);
    e = sb_q.pop_front(); {exp_hi, exp_lo} = e;
    checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL mtlo: got %h want %h", {hi, lo}, e); end
  endtask

  task automatic test_cancel();
    drive(HL_DIVU, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cancel_pre_busy: got %b want 1", busy); end
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b want 0", busy); end
    checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin errors++; $display("FAIL cancel_hilo: got %h want %h", {hi, lo}, {exp_hi, exp_lo}); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    int cyc;
    bit held;
    sb_q.push_back(model(HL_DIVU, 32'd1000, 32'd3));
    drive(HL_DIVU, 32'd1000, 32'd3);
    step();
    step();
    drive(HL_MULT, 32'd5, 32'd9);
    checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin errors++; $display("FAIL b2b_mult_ignored: got %h want %h", {hi, lo}, {exp_hi, exp_lo}); end
    wait_div(cyc, held);
    checks++; if (!held || cyc != 29) begin errors++; $display("FAIL b2b_hold: held=%0b cycles=%0d want held=1 cycles=29", held, cyc); end
    e = sb_q.pop_front(); {exp_hi, exp_lo} = e;
    checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL b2b_result: got %h want %h", {hi, lo}, e); end
    step();
    checks++; if ({hi, lo} !== e || busy !== 1'b0) begin errors++; $display("FAIL b2b_after: got %h busy=%b want %h busy=0", {hi, lo}, busy, e); end
  endtask

  task automatic test_random();
    logic [63:0] e;
    logic [2:0]  o;
    logic [31:0] a, b;
    int cyc;
    bit held;
    for (int i = 0; i < 10; i++) begin
      o = 3'(HL_MULT + $urandom_range(0, 3));
      a = $urandom();
      b = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom();
      if (i == 7) begin o = HL_DIV; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (i == 8) begin o = HL_DIV; b = 32'd0; end
      sb_q.push_back(model(o, a, b));
      drive(o, a, b);
      wait_div(cyc, held);
      e = sb_q.pop_front(); {exp_hi, exp_lo} = e;
      checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL rand%0d op=%0d a=%h b=%h: got %h want %h", i, o, a, b, {hi, lo}, e); end
    end
  endtask

  task automatic test_async_reset();
    drive(HL_DIVU, 32'd100, 32'd7);
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL async_reset: busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    step();
    reset_n = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    sb_q.delete();
    sb_q.push_back(model(HL_MTHI, 32'hDEAD_BEEF, 32'd0));
    drive(HL_MTHI, 32'hDEAD_BEEF, 32'd0);
    checks++; if ({hi, lo} !== sb_q[0]) begin errors++; $display("FAIL post_reset_mthi: got %h want %h", {hi, lo}, sb_q[0]); end
    void'(sb_q.pop_front());
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_move();
    test_cancel();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
